// File: rtl/operand_fetch.sv
// Operand fetch stage: drives the register-file read ports, bypasses same-cycle
// writeback, interlocks on a pending-write scoreboard and registers the result for execute.
module operand_fetch #(
  parameter int OP_W = 6,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OP_W-1:0] id_op,
  input  logic [4:0]      id_rs0,
  input  logic [4:0]      id_rs1,
  input  logic            id_use0,
  input  logic            id_use1,
  input  logic [4:0]      id_rd,
  input  logic            id_wr,
  input  logic [31:0]     id_imm,
  output logic [4:0]      rf_raddr0,
  output logic [4:0]      rf_raddr1,
  input  logic [31:0]     rf_rdata0,
  input  logic [31:0]     rf_rdata1,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OP_W-1:0] ex_op,
  output logic [31:0]     ex_a,
  output logic [31:0]     ex_b,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_wr
);

  logic [NREG-1:0] pend_q, pend_d;
  logic            ex_valid_q, ex_valid_d;
  logic [OP_W-1:0] ex_op_q, ex_op_d;
  logic [31:0]     ex_a_q, ex_a_d;
  logic [31:0]     ex_b_q, ex_b_d;
  logic [31:0]     ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_wr_q, ex_wr_d;

  logic        wb_hit0, wb_hit1, wb_hitd;
  logic [31:0] opa, opb;
  logic        hazard, space, accept;

  assign rf_raddr0 = id_rs0;
  assign rf_raddr1 = id_rs1;

  // A writeback retiring this cycle both feeds the operand and releases the interlock.
  always_comb begin
    wb_hit0 = wb_we && (wb_addr == id_rs0);
    wb_hit1 = wb_we && (wb_addr == id_rs1);
    wb_hitd = wb_we && (wb_addr == id_rd);
    opa     = wb_hit0 ? wb_data : rf_rdata0;
    opb     = wb_hit1 ? wb_data : rf_rdata1;
    hazard  = (id_use0 && pend_q[id_rs0] && !wb_hit0) ||
              (id_use1 && pend_q[id_rs1] && !wb_hit1) ||
              (id_wr   && pend_q[id_rd]  && !wb_hitd);
    space    = !ex_valid_q || ex_ready;
    id_ready = space && !hazard && !flush;
    accept   = id_valid && id_ready;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_d    = ex_wr_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = id_op;
      ex_a_d     = opa;
      ex_b_d     = opb;
      ex_imm_d   = id_imm;
      ex_rd_d    = id_rd;
      ex_wr_d    = id_wr;
    end else if (ex_valid_q && ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // Order matters: set beats writeback clear, and a flushed write beats everything.
  always_comb begin
    pend_d = pend_q;
    if (wb_we) begin
      pend_d[wb_addr] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (accept && id_wr) begin
      pend_d[id_rd] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    if (flush && ex_valid_q && ex_wr_q) begin
      pend_d[ex_rd_q] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= {NREG{1'b0}};
      ex_valid_q <= 1'b0;
      ex_op_q    <= {OP_W{1'b0}};
      ex_a_q     <= 32'h0000_0000;
      ex_b_q     <= 32'h0000_0000;
      ex_imm_q   <= 32'h0000_0000;
      ex_rd_q    <= 5'd0;
      ex_wr_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_q    <= ex_wr_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rd    = ex_rd_q;
  assign ex_wr    = ex_wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file behind the read ports.
module tb_operand_fetch;

  localparam int OP_W = 6;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic            id_ready;
  logic [OP_W-1:0] id_op;
  logic [4:0]      id_rs0, id_rs1, id_rd;
  logic            id_use0, id_use1, id_wr;
  logic [31:0]     id_imm;
  logic [4:0]      rf_raddr0, rf_raddr1;
  logic [31:0]     rf_rdata0, rf_rdata1;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            flush;
  logic            ex_valid, ex_ready;
  logic [OP_W-1:0] ex_op;
  logic [31:0]     ex_a, ex_b, ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_wr;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;

  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  operand_fetch #(.OP_W(OP_W), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rs0(id_rs0), .id_rs1(id_rs1), .id_use0(id_use0), .id_use1(id_use1),
    .id_rd(id_rd), .id_wr(id_wr), .id_imm(id_imm),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; the register file takes the writeback just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (wb_we) rf[wb_addr] = wb_data;
  endtask

  task automatic present(input logic v, input logic [4:0] rs0, input logic u0,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rd, input logic wr,
                         input logic [OP_W-1:0] op, input logic [31:0] imm);
    id_valid = v; id_rs0 = rs0; id_use0 = u0; id_rs1 = rs1; id_use1 = u1;
    id_rd = rd; id_wr = wr; id_op = op; id_imm = imm;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0; wb_we = 1'b0;
    wb_addr = 5'd0; wb_data = 32'h0;
    present(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 6'h3F, 32'hFFFF_FFFF);
    step();
    step();
    total++;
    if (ex_valid !== 1'b0 || ex_op !== 6'h00 || ex_a !== 32'h0 || ex_b !== 32'h0 ||
        ex_imm !== 32'h0 || ex_rd !== 5'd0 || ex_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h imm=%h rd=%0d wr=%b, want all 0",
               ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_wr);
    end
    rst_n = 1'b1;
    present(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 6'h3F, 32'hFFFF_FFFF);
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
  endtask

  task automatic test_basic();
    rf[3] = 32'h11; rf[4] = 32'h22;
    present(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 6'h2A, 32'h0000_1234);
    total++;
    if (rf_raddr0 !== 5'd3 || rf_raddr1 !== 5'd4) begin
      bad++;
      $display("FAIL basic_raddr: got %0d/%0d want 3/4", rf_raddr0, rf_raddr1);
    end
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_b !== 32'h22 || ex_rd !== 5'd5 ||
        ex_wr !== 1'b1 || ex_op !== 6'h2A || ex_imm !== 32'h0000_1234) begin
      bad++;
      $display("FAIL basic_capture: got v=%b a=%h b=%h rd=%0d wr=%b op=%h imm=%h want 1/11/22/5/1/2a/1234",
               ex_valid, ex_a, ex_b, ex_rd, ex_wr, ex_op, ex_imm);
    end
  endtask

  task automatic test_raw();
    present(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'h01, 32'h0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (id_ready !== 1'b0) begin
        bad++;
        $display("FAIL raw_stall%0d: id_ready got %b want 0", i, id_ready);
      end
      step();
    end
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL raw_drained: ex_valid got %b want 0", ex_valid);
    end
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_DEAD;
    #1;
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL raw_release: id_ready got %b want 1", id_ready);
    end
    step();
    wb_we = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_a !== 32'h0000_DEAD) begin
      bad++;
      $display("FAIL raw_bypass: got v=%b a=%h want 1/dead", ex_valid, ex_a);
    end
    present(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'h01, 32'h0);
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL raw_pend_cleared: id_ready got %b want 1", id_ready);
    end
  endtask

  task automatic test_backpressure();
    present(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 6'h01, 32'h0000_AAAA);
    step();
    ex_ready = 1'b0;
    present(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 6'h02, 32'h0000_BBBB);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_b !== 32'h22 ||
          ex_imm !== 32'h0000_AAAA || ex_op !== 6'h01) begin
        bad++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h b=%h imm=%h op=%h want 0/1/11/22/aaaa/01",
                 i, id_ready, ex_valid, ex_a, ex_b, ex_imm, ex_op);
      end
      step();
    end
    ex_ready = 1'b1;
    #1;
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready: id_ready got %b want 1", id_ready);
    end
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_a !== 32'h22 || ex_b !== 32'h11 || ex_imm !== 32'h0000_BBBB ||
        ex_op !== 6'h02) begin
      bad++;
      $display("FAIL bp_next: got v=%b a=%h b=%h imm=%h op=%h want 1/22/11/bbbb/02",
               ex_valid, ex_a, ex_b, ex_imm, ex_op);
    end
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'h00, 32'h0);
    step();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: ex_valid got %b want 0", ex_valid);
    end
  endtask

  task automatic test_flush();
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 6'h07, 32'h7);
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
      bad++;
      $display("FAIL flush_setup: got v=%b rd=%0d want 1/7", ex_valid, ex_rd);
    end
    ex_ready = 1'b0; flush = 1'b1;
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 6'h08, 32'h8);
    total++;
    if (id_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_blocks: id_ready got %b want 0", id_ready);
    end
    step();
    flush = 1'b0; ex_ready = 1'b1;
    present(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'h00, 32'h0);
    total++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_kill: got v=%b rdy=%b want 0/1 (pend7 cleared)", ex_valid, id_ready);
    end
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 6'h00, 32'h0);
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_no_set8: id_ready got %b want 1", id_ready);
    end
  endtask

  task automatic test_waw();
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 6'h09, 32'h9);
    step();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 6'h0A, 32'hA);
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL waw_accept: id_ready got %b want 1", id_ready);
    end
    step();
    wb_we = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_op !== 6'h0A) begin
      bad++;
      $display("FAIL waw_capture: got v=%b rd=%0d op=%h want 1/9/0a", ex_valid, ex_rd, ex_op);
    end
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 6'h00, 32'h0);
    total++;
    if (id_ready !== 1'b0) begin
      bad++;
      $display("FAIL waw_set_wins: id_ready got %b want 0", id_ready);
    end
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9A;
    step();
    wb_we = 1'b0;
    #1;
    total++;
    if (id_ready !== 1'b1) begin
      bad++;
      $display("FAIL waw_cleared: id_ready got %b want 1", id_ready);
    end
  endtask

  task automatic test_back_to_back();
    rf[0] = 32'h55; rf[12] = 32'h1212;
    present(1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 6'h11, 32'h1);
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_CAFE;
    #1;
    step();
    wb_we = 1'b0;
    total++;
    if (ex_a !== 32'h55 || ex_b !== 32'h0000_CAFE || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: got v=%b a=%h b=%h want 1/55/cafe", ex_valid, ex_a, ex_b);
    end
    present(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 6'h12, 32'h2);
    step();
    total++;
    if (ex_a !== 32'h11 || ex_b !== 32'h0000_CAFE || ex_op !== 6'h12 || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: got v=%b a=%h b=%h op=%h want 1/11/cafe/12",
               ex_valid, ex_a, ex_b, ex_op);
    end
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'h00, 32'h0);
    step();
  endtask

  task automatic test_reset_mid();
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 6'h14, 32'h14);
    step();
    rst_n = 1'b0; ex_ready = 1'b0;
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'h00, 32'h0);
    step();
    rst_n = 1'b1;
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 6'h00, 32'h0);
    total++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b rdy=%b rd=%0d want 0/1/0", ex_valid, id_ready, ex_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    test_reset();
    test_basic();
    test_raw();
    test_backpressure();
    test_flush();
    test_waw();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute pipeline stage that owns both read ports of `register_file`.
- Drives `read_address0`/`read_address1` from decoded source fields and captures `read_data0`/`read_data1` into an output pipeline register.
- Bypasses same-cycle writeback data, because the register file write lands only at posedge.
- Keeps a 32-entry pending-write scoreboard that interlocks RAW/WAW hazards against in-flight results.
- Valid/ready handshake on both sides.

Parameters:
- OP_W, 6, width of the opaque operation code passed through to execute
- NREG, 32, number of architectural registers (scoreboard depth; fixed to match the 5-bit addresses)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_op  in  OP_W  operation code
- id_rs0  in  5  source register 0
- id_rs1  in  5  source register 1
- id_use0  in  1  instruction reads rs0
- id_use1  in  1  instruction reads rs1
- id_rd  in  5  destination register
- id_wr  in  1  instruction writes rd
- id_imm  in  32  immediate
- rf_raddr0  out  5  to `register_file` `read_address0`
- rf_raddr1  out  5  to `register_file` `read_address1`
- rf_rdata0  in  32  from `read_data0`
- rf_rdata1  in  32  from `read_data1`
- wb_we  in  1  writeback enable (same net as `register_file` `write_enable`)
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- flush  in  1  kill the instruction held in the output register
- ex_valid  out  1  output register holds an instruction
- ex_ready  in  1  execute accepts
- ex_op  out  OP_W  registered op
- ex_a  out  32  operand 0
- ex_b  out  32  operand 1
- ex_imm  out  32  registered immediate
- ex_rd  out  5  registered destination
- ex_wr  out  1  registered write flag

Behaviour:
- Reset (rst_n=0 at posedge): ex_valid=0; ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_wr = 0; all scoreboard bits = 0. Reset mid-operation discards the held instruction and all pending bits.
- rf_raddr0=id_rs0 and rf_raddr1=id_rs1, combinationally and always, regardless of id_valid.
- Operand select, per port: if wb_we && wb_addr==rsN, take wb_data (bypass); else take rf_rdataN. No register is hardwired to zero.
- hazard = (id_use0 && pend[rs0] && !(wb_we && wb_addr==rs0)) || (id_use1 && pend[rs1] && !(wb_we && wb_addr==rs1)) || (id_wr && pend[rd] && !(wb_we && wb_addr==rd)).
- space = !ex_valid || ex_ready.
- id_ready = space && !hazard && !flush. It is independent of id_valid.
- Accept = id_valid && id_ready. On accept, at the next edge: ex_valid=1, fields captured, operands per select rule. Latency is 1 cycle.
- Without an accept: if ex_valid && ex_ready, then ex_valid=0. Otherwise all outputs hold stable while ex_valid && !ex_ready.
- Scoreboard clear: wb_we clears pend[wb_addr].
- Scoreboard set: accept with id_wr sets pend[id_rd]. If set and clear hit the same address in the same cycle, set wins.
- flush: at the next edge ex_valid=0. If ex_valid && ex_wr, pend[ex_rd] is also cleared, and this takes priority over a wb set on the same bit. flush blocks acceptance that cycle. Older instructions past execute are unaffected.
- A result leaving execute is expected to return on wb_* exactly once. Double-clear is harmless.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> ex_valid=0, all outputs 0, id_ready=1 after release.
- Basic fetch: register file r3=0x11, r4=0x22; issue rs0=3, rs1=4, rd=5, wr=1, ex_ready=1 -> next cycle ex_a=0x11, ex_b=0x22, ex_rd=5; pend[5]=1.
- RAW interlock: after issuing a write to r5, present rs0=5 -> id_ready=0 until the cycle where wb_we=1, wb_addr=5, wb_data=0xDEAD. Accept occurs that cycle with ex_a=0xDEAD (bypass), and pend[5]=0 afterwards.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0. When ex_ready=1 and id_valid=1, the new instruction is captured in the same cycle.
- Flush: held instruction with rd=7, wr=1; assert flush -> ex_valid=0 next cycle, pend[7]=0, id_ready=0 during the flush cycle.
- WAW with simultaneous clear/set: pend[9]=1; issue rd=9 while wb_addr=9, wb_we=1 -> accepted, pend[9] remains 1.
